// File: rtl/dma_mem_pkg.sv
// Shared constants and types for the DMA / Wishbone memory arbiter slice.
package dma_mem_pkg;

    localparam int ADDR_W_DEF      = 32;
    localparam int DATA_W_DEF      = 32;
    localparam int READ_LAT_DEF    = 10;
    localparam int WB_MAX_WAIT_DEF = 4;

    localparam logic SRC_DMA = 1'b0;
    localparam logic SRC_WB  = 1'b1;

    typedef enum logic {
        WB_IDLE    = 1'b0,
        WB_RD_PEND = 1'b1
    } wb_state_t;

endpackage

// File: rtl/dma_mem_tag_pipe.sv
// Shift pipeline of {valid, src} tags that tracks reads in flight to the memory.
module dma_mem_tag_pipe
    import dma_mem_pkg::*;
#(
    parameter int READ_LAT = READ_LAT_DEF
) (
    input  logic clk,
    input  logic flush,
    input  logic load_valid,
    input  logic load_src,
    output logic head_valid,
    output logic head_src
);

    logic [READ_LAT-1:0] vld;
    logic [READ_LAT-1:0] src;

    always_ff @(posedge clk) begin
        if (flush) begin
            vld <= '0;
            src <= '0;
        end else begin
            vld[0] <= load_valid;
            src[0] <= load_src;
            for (int i = 1; i < READ_LAT; i++) begin
                vld[i] <= vld[i-1];
                src[i] <= src[i-1];
            end
        end
    end

    assign head_valid = vld[READ_LAT-1];
    assign head_src   = src[READ_LAT-1];

endmodule

// File: rtl/dma_mem_arbiter.sv
// Shares one pipelined memory between a Wishbone slave and a DMA engine, DMA first.
// Define DMA_MEM_ARB_STATS_EN to add the beat/op/stall statistic counters.
//
//   state      | meaning
//   WB_IDLE    | no WB read outstanding; WB request may be granted
//   WB_RD_PEND | WB read issued, waiting for its tag at the pipeline head
module dma_mem_arbiter
    import dma_mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int READ_LAT    = READ_LAT_DEF,
    parameter int WB_MAX_WAIT = WB_MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [3:0]        wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              wb_ack,
    input  logic              dma_en,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_data_i,
    output logic              dma_ready,
    output logic [DATA_W-1:0] dma_data_o,
    output logic              dma_read_ack,
    output logic              mem_stb,
    output logic              mem_we,
    output logic [3:0]        mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMA_MEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_dma_beats,
    output logic [31:0]       stat_wb_ops,
    output logic [31:0]       stat_wb_stall
`endif
);

    // Starvation timer counts down from WB_MAX_WAIT; terminal count forces WB through.
    localparam logic [3:0] WAIT_INIT = 4'(WB_MAX_WAIT);

    wb_state_t  state;
    logic [3:0] wait_rem;
    logic       wb_is_wr;
    logic       wb_pend;
    logic       force_wb;
    logic       dma_grant;
    logic       wb_grant;
    logic       rd_grant;
    logic       head_valid;
    logic       head_src;

    always_comb begin
        wb_is_wr  = |wb_we;
        wb_pend   = wb_en && (state == WB_IDLE) && !rst;
        force_wb  = wb_pend && (wait_rem == 4'd0);
        dma_grant = dma_en && !force_wb && !rst;
        wb_grant  = wb_pend && !dma_grant;
        rd_grant  = (dma_grant && !dma_we) || (wb_grant && !wb_is_wr);
        dma_ready = !force_wb;
    end

    always_comb begin
        mem_stb = dma_grant || wb_grant;
        if (dma_grant) begin
            mem_we    = dma_we;
            mem_sel   = 4'b1111;
            mem_addr  = dma_addr;
            mem_wdata = dma_data_i;
        end else begin
            mem_we    = wb_grant && wb_is_wr;
            mem_sel   = wb_is_wr ? wb_we : 4'b1111;
            mem_addr  = wb_addr;
            mem_wdata = wb_data_i;
        end
    end

    dma_mem_tag_pipe #(
        .READ_LAT (READ_LAT)
    ) u_tag_pipe (
        .clk        (clk),
        .flush      (rst),
        .load_valid (rd_grant),
        .load_src   (wb_grant ? SRC_WB : SRC_DMA),
        .head_valid (head_valid),
        .head_src   (head_src)
    );

    always_comb begin
        dma_read_ack = !rst && head_valid && (head_src == SRC_DMA);
        wb_ack       = (wb_grant && wb_is_wr) ||
                       (!rst && head_valid && (head_src == SRC_WB));
        wb_data_o    = mem_rdata;
        dma_data_o   = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WB_IDLE;
            wait_rem <= WAIT_INIT;
        end else begin
            case (state)
                WB_IDLE: begin
                    if (wb_grant && !wb_is_wr) begin
                        state <= WB_RD_PEND;
                    end
                end
                WB_RD_PEND: begin
                    if (head_valid && (head_src == SRC_WB)) begin
                        state <= WB_IDLE;
                    end
                end
            endcase

            if (!wb_en || wb_grant) begin
                wait_rem <= WAIT_INIT;
            end else if (wb_pend && (wait_rem != 4'd0)) begin
                wait_rem <= wait_rem - 4'd1;
            end
        end
    end

`ifdef DMA_MEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_dma_beats <= '0;
            stat_wb_ops    <= '0;
            stat_wb_stall  <= '0;
        end else begin
            stat_dma_beats <= stat_dma_beats + 32'(dma_grant);
            stat_wb_ops    <= stat_wb_ops + 32'(wb_grant);
            stat_wb_stall  <= stat_wb_stall + 32'(wb_pend && !wb_grant);
        end
    end
`endif

endmodule

// File: doc/dma_mem_arbiter.md
Name: dma_mem_arbiter

Overview:
- Sequences and shares one fixed-latency pipelined memory (exmem_pipeline-style stb/we/sel/addr/dat port) between a Wishbone slave path and a DMA engine.
- At most one memory command per cycle. The DMA gets priority. A starvation counter guarantees the Wishbone side a slot.
- Read data returns READ_LAT cycles after issue and is routed back to the requester that issued it, using a tag shift pipeline.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory.
- DATA_W, 32, data width.
- READ_LAT, 10, cycles from memory read issue to valid mem_rdata (range 1..15).
- WB_MAX_WAIT, 4, maximum consecutive cycles a pending WB request loses to DMA before it is forced through (range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wb_en  in  1  WB request; held high until wb_ack
- wb_we  in  4  byte write enables; 0 = read
- wb_addr  in  ADDR_W  WB address
- wb_data_i  in  DATA_W  WB write data
- wb_data_o  out  DATA_W  WB read data
- wb_ack  out  1  one-cycle WB completion
- dma_en  in  1  DMA beat request; pulse, valid only with dma_ready
- dma_we  in  1  1 = write, 0 = read
- dma_addr  in  ADDR_W  DMA address
- dma_data_i  in  DATA_W  DMA write data
- dma_ready  out  1  beat accepted this cycle when dma_en high
- dma_data_o  out  DATA_W  DMA read data
- dma_read_ack  out  1  one-cycle DMA read-data valid
- mem_stb  out  1  memory command strobe
- mem_we  out  1  memory write
- mem_sel  out  4  byte select
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data (valid READ_LAT after read issue)

Behaviour:
- Reset: wb_ack=0, dma_read_ack=0, mem_stb=0, tag pipeline cleared, wait counter=0, FSM=IDLE. dma_ready=1 combinationally unless WB is forced. wb_data_o and dma_data_o follow mem_rdata and are undefined-valued but harmless.
- WB FSM states:
  - IDLE: wb_en high and granted. A write issues and wb_ack=1 in the same cycle, combinationally; FSM stays IDLE. A read issues and goes to RD_PEND.
  - RD_PEND: no WB issue. Leaves when the WB tag reaches the pipeline head: wb_ack=1 that cycle, back to IDLE.
  - The one-cycle wb_ack overlaps the last wb_en cycle. A WB request is never reissued while in RD_PEND.
- Arbitration, each cycle:
  - force_wb = (wait_cnt == WB_MAX_WAIT) and WB pending in IDLE.
  - If force_wb, WB is granted and dma_ready=0.
  - Otherwise, if dma_en, DMA is granted.
  - Otherwise, a pending WB in IDLE is granted.
- wait_cnt: increments when WB is pending in IDLE and not granted; clears on WB grant or when wb_en is low; saturates at WB_MAX_WAIT.
- Memory mux:
  - DMA grant: mem_sel=4'b1111, mem_we=dma_we.
  - WB grant: mem_sel = wb_we for writes, 4'b1111 for reads; mem_we = |wb_we.
  - mem_stb is high only on a grant.
- Tag pipeline: READ_LAT stages of {valid, src}. Stage 0 loads valid=1 on a read grant, with src = 1 for WB, 0 for DMA. Writes load valid=0. At the head: valid&src=0 gives dma_read_ack=1; valid&src=1 gives wb_ack=1. wb_data_o = dma_data_o = mem_rdata.
- Simultaneous events:
  - A write grant in the same cycle as a read return is legal; both outputs are asserted.
  - Back-to-back DMA reads return back-to-back, in order.
- DMA beat with dma_ready=0: it is not accepted. The DMA must hold it or retry; the arbiter never drops an accepted beat.
- Reset mid-operation flushes in-flight tags; no ack is produced for them.

Optional Feature:
- Macro DMA_MEM_ARB_STATS_EN.
- When defined, adds three outputs:
  - stat_dma_beats [31:0]: accepted DMA beats.
  - stat_wb_ops [31:0]: WB grants.
  - stat_wb_stall [31:0]: cycles WB was pending but not granted.
- All three wrap modulo 2^32, clear on rst, and are read-only.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package dma_mem_pkg: ADDR_W/DATA_W defaults, READ_LAT default, source-tag constants SRC_DMA=0 and SRC_WB=1, WB FSM state encoding.
- One sub-module: dma_mem_tag_pipe (parameterised READ_LAT shift register of {valid, src}, with synchronous flush).

Test Plan:
- Single WB read of addr 0x10 with memory preloaded 0xDEADBEEF, no DMA → mem_stb at cycle 0; wb_ack exactly 10 cycles later with wb_data_o=0xDEADBEEF; no second issue.
- WB write 0x12345678, wb_we=4'b0011, idle DMA → wb_ack same cycle, mem_sel=4'b0011, mem_we=1.
- DMA reads of addr 0..7, one beat per cycle → dma_read_ack high for 8 consecutive cycles starting 10 cycles after the first beat; data returned in order.
- Continuous dma_en while a WB read is pending, WB_MAX_WAIT=4 → WB granted on the 5th cycle with dma_ready=0 for that cycle only; wb_ack 10 cycles later, not misrouted to DMA.
- Interleave: DMA read at t, WB read at t+1 → dma_read_ack at t+10 and wb_ack at t+11, with no cross-routing.
- Assert rst 3 cycles after a DMA read issue → no dma_read_ack afterwards; all outputs at reset values the next cycle.
